// File: rtl/audio_pwm_dac.sv
// Audio output stage: small sample FIFO, sample-rate divider and PWM generator.
// Samples arrive over valid/ready, leave the FIFO one per sample period, and
// are rendered as a PWM stream whose duty only changes at a PWM period boundary.
module audio_pwm_dac #(
    parameter int SAMPLE_W   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SAMPLE_DIV = 2268
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          s_valid,
    input  logic [SAMPLE_W-1:0]           s_data,
    output logic                          s_ready,
    output logic                          pwm_out,
    output logic                          sample_tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underrun_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(SAMPLE_DIV);

    localparam logic [DW-1:0]       DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [LW-1:0]       LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [SAMPLE_W-1:0] MID       = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] PWM_LAST  = {SAMPLE_W{1'b1}};

    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level;
    logic [LW-1:0]       level_next;
    logic                ready_q;
    logic [DW-1:0]       div_cnt;
    logic [SAMPLE_W-1:0] pwm_cnt;
    logic [SAMPLE_W-1:0] pending;
    logic [SAMPLE_W-1:0] duty;
    logic [15:0]         underruns;
    logic                push;
    logic                pop;
    logic                empty;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign empty        = (level == '0);
    assign sample_tick  = enable && (div_cnt == DIV_LAST);
    assign push         = s_valid && ready_q;
    assign pop          = sample_tick && !empty;
    assign s_ready      = ready_q;
    assign fifo_level   = level;
    assign underrun_cnt = underruns;

    // Next FIFO occupancy; a simultaneous push and pop leave it unchanged.
    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    // Sample storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level   <= level_next;
            ready_q <= (level_next != LVL_FULL);
        end
    end

    // Sample-period divider; parked at zero while playback is disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (!enable || sample_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // On each tick take the FIFO head, or fall back to silence and count an underrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= MID;
            underruns <= '0;
        end else if (sample_tick) begin
            if (empty) begin
                pending   <= MID;
                underruns <= sat_inc(underruns);
            end else begin
                pending   <= mem[rd_ptr];
            end
        end
    end

    // PWM counter and duty latch; duty is loaded only on the last count of a period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            duty    <= MID;
            pwm_out <= 1'b0;
        end else begin
            if (!enable) begin
                pwm_cnt <= '0;
            end else begin
                pwm_cnt <= pwm_cnt + SAMPLE_W'(1);
                if (pwm_cnt == PWM_LAST) begin
                    duty <= pending;
                end
            end
            pwm_out <= enable && (pwm_cnt < duty);
        end
    end

endmodule
